// File: rtl/range_counter.sv
// Programmable bounded counter: wrap / bounce / one-shot between run-time bounds lo..hi.
// One-cycle latency from en to count; all outputs registered; no backpressure (en is a plain step strobe).
module range_counter #(
  parameter int WIDTH  = 4,
  parameter int RST_LO = 3,
  parameter int RST_HI = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             dir_q,
  output logic             tc,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic {RUN, DONE} state_t;

  localparam logic [1:0]       M_BOUNCE  = 2'b01;
  localparam logic [1:0]       M_ONESHOT = 2'b10;
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LO_INIT   = WIDTH'(RST_LO);
  localparam logic [WIDTH-1:0] HI_INIT   = WIDTH'(RST_HI);

  state_t           state, state_d;
  logic [WIDTH-1:0] lo, lo_d, hi, hi_d, count_d, term;
  logic [1:0]       mode_q, mode_d;
  logic             dir_d, tc_d, err_d, restart;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo      <= LO_INIT;
      hi      <= HI_INIT;
      mode_q  <= 2'b00;
      dir_q   <= 1'b1;
      state   <= RUN;
      count   <= LO_INIT;
      tc      <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      lo      <= lo_d;
      hi      <= hi_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      state   <= state_d;
      count   <= count_d;
      tc      <= tc_d;
      cfg_err <= err_d;
    end
  end

  always_comb begin
    lo_d    = lo;
    hi_d    = hi;
    mode_d  = mode_q;
    dir_d   = dir_q;
    state_d = state;
    count_d = count;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    restart = 1'b0;
    term    = dir_q ? hi : lo;

    if (cfg_we) begin
      // A rejected write leaves everything alone, including this cycle's en.
      if (cfg_lo <= cfg_hi) begin
        lo_d    = cfg_lo;
        hi_d    = cfg_hi;
        restart = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (clr) begin
      restart = 1'b1;
    end else if (en && state == RUN) begin
      if (count != term) begin
        count_d = dir_q ? count + ONE : count - ONE;
      end else begin
        tc_d = 1'b1;
        case (mode_q)
          M_BOUNCE: begin
            dir_d = ~dir_q;
            if (lo != hi) count_d = dir_q ? hi - ONE : lo + ONE;
          end
          M_ONESHOT: state_d = DONE;
          default:   count_d = dir_q ? lo : hi;
        endcase
      end
    end

    // Start value uses the bounds being written this cycle, not the old ones.
    if (restart) begin
      mode_d  = mode;
      dir_d   = dir;
      count_d = dir ? lo_d : hi_d;
      state_d = RUN;
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_range_counter.sv
// Randomised and scenario-driven bench for range_counter against a behavioural model.
module tb_range_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, clr, cfg_we, dir;
  logic [3:0] cfg_lo, cfg_hi;
  logic [1:0] mode;
  logic [3:0] count;
  logic       dir_q, tc, done, cfg_err;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state
  int m_lo, m_hi, m_mode, m_cnt;
  bit m_dir, m_done, m_tc, m_err;

  range_counter #(.WIDTH(4), .RST_LO(3), .RST_HI(12)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .cfg_we(cfg_we),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .mode(mode), .dir(dir),
    .count(count), .dir_q(dir_q), .tc(tc), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lo = 3; m_hi = 12; m_mode = 0; m_dir = 1; m_cnt = 3;
    m_done = 0; m_tc = 0; m_err = 0;
  endtask

  task automatic model_restart();
    m_mode = mode; m_dir = dir; m_done = 0;
    m_cnt = m_dir ? m_lo : m_hi;
  endtask

  // Behaviour of one clock edge in terms of the counting rules.
  task automatic model_edge();
    int target;
    m_tc = 0; m_err = 0;
    if (cfg_we) begin
      if (cfg_lo <= cfg_hi) begin
        m_lo = cfg_lo; m_hi = cfg_hi;
        model_restart();
      end else begin
        m_err = 1;
      end
    end else if (clr) begin
      model_restart();
    end else if (en && !m_done) begin
      target = m_dir ? m_hi : m_lo;
      if (m_cnt != target) begin
        m_cnt = m_dir ? m_cnt + 1 : m_cnt - 1;
      end else begin
        m_tc = 1;
        if (m_mode == 1) begin
          if (m_lo != m_hi) m_cnt = m_dir ? m_hi - 1 : m_lo + 1;
          m_dir = !m_dir;
        end else if (m_mode == 2) begin
          m_done = 1;
        end else begin
          m_cnt = m_dir ? m_lo : m_hi;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},   count,   m_cnt);
    check({tag, ".dir_q"},   dir_q,   m_dir);
    check({tag, ".tc"},      tc,      m_tc);
    check({tag, ".done"},    done,    m_done);
    check({tag, ".cfg_err"}, cfg_err, m_err);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input bit we, input int lo, input int hi, input int md,
                       input bit dr, input bit c, input bit e);
    cfg_we = we; cfg_lo = 4'(lo); cfg_hi = 4'(hi); mode = 2'(md);
    dir = dr; clr = c; en = e;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 0);
    model_reset();
    #12;
    check("rst.count", count, 3);
    check("rst.dir_q", dir_q, 1);
    check("rst.tc", tc, 0);
    check("rst.done", done, 0);
    check("rst.cfg_err", cfg_err, 0);
    @(negedge clk); reset_n = 1'b1;

    // Default wrap up, 3..12
    drive(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 12; i++) step("wrap");
    check("wrap.end", count, 5);

    // Bounce 2..5 up
    drive(1, 2, 5, 1, 1, 0, 1);
    step("bcfg");
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("bounce");

    // One-shot 0..3 down, then clr
    drive(1, 0, 3, 2, 0, 0, 1);
    step("ocfg");
    drive(0, 0, 0, 2, 0, 0, 1);
    for (int i = 0; i < 6; i++) step("oneshot");
    check("oneshot.done", done, 1);
    drive(0, 0, 0, 2, 0, 1, 1);
    step("oclr");
    check("oclr.count", count, 3);

    // Rejected config mid-count
    drive(1, 3, 12, 0, 1, 0, 1);
    step("wcfg");
    drive(0, 0, 0, 0, 1, 0, 1);
    step("run");
    drive(1, 9, 4, 1, 0, 0, 1);
    step("badcfg");
    check("badcfg.err", cfg_err, 1);
    drive(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("after_bad");

    // lo == hi
    drive(1, 7, 7, 0, 1, 0, 1);
    step("eqcfg");
    drive(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step("eq_held");
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1, 0, i[0]);
      step("eq_toggle");
    end
    drive(1, 7, 7, 1, 0, 0, 1);
    step("eqb_cfg");
    drive(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("eq_bounce");

    // Async reset at count 8
    drive(1, 3, 12, 0, 1, 0, 1);
    step("acfg");
    drive(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step("to8");
    check("pre_rst.count", count, 8);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk); reset_n = 1'b1;

    // cfg_we and clr together
    drive(1, 1, 6, 1, 0, 1, 1);
    step("we_clr");
    check("we_clr.count", count, 6);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0 && a > b) begin
        int t;
        t = a; a = b; b = t;
      end
      if ($urandom_range(0, 7) == 0) b = a;
      drive($urandom_range(0, 15) == 0, a, b, $urandom_range(0, 3),
            1'($urandom_range(0, 1)), $urandom_range(0, 23) == 0,
            $urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
